cpu_output_collector: RTL and testbench
=======================================

# cpu_output_collector

Capture-side partner of the CPU output port. It launches a program run by pulsing the CPU's `startIO`, then captures every 36-bit word the CPU presents with `outFlag`. Captured words are buffered in a first-word-fall-through FIFO and handed to a downstream consumer (display/UART/host bridge) over a valid/ready handshake. The block reports completion once the CPU raises `endFlag` and the buffer has drained.

## Interface

- `WIDTH`, 36, data word width; must match the CPU `out` width.
- `DEPTH`, 16, FIFO entries; must be a power of two.
- `PTRWIDTH`, 4, log2(`DEPTH`).

- `clock`  in  1  Single clock; all state updates on its rising edge.
- `reset`  in  1  Asynchronous, active-low reset.
- `start`  in  1  User/host run request, level; the block edge-detects it internally.
- `startIO`  out  1  One-cycle pulse to the CPU `startIO` input.
- `outFlag`  in  1  CPU strobe: `dataIn` is valid this cycle.
- `endFlag`  in  1  CPU end-of-program indication.
- `dataIn`  in  `WIDTH`  CPU `out` bus.
- `rdValid`  out  1  FIFO is non-empty, and `rdData` is valid.
- `rdReady`  in  1  Consumer accepts `rdData` this cycle.
- `rdData`  out  `WIDTH`  Head-of-FIFO word.
- `count`  out  `PTRWIDTH+1`  FIFO occupancy, from 0 to `DEPTH`.
- `overflow`  out  1  Sticky: at least one word was dropped because the FIFO was full.
- `done`  out  1  Run finished and FIFO empty.

## Operation

- **Start detection.** `startRise = start & ~start_q`, where `start_q` is `start` registered.
- **States.** The FSM has four states: IDLE, RUN, DRAIN, DONE.
- **IDLE.**
  - On `startRise`, the block clears the pointers, `count` and `overflow`, asserts `startIO` for one cycle, and moves to RUN.
  - All other inputs are ignored.
- **RUN.**
  - **Write.** When `outFlag`=1 and the FIFO is not full, `dataIn` is written at `wrPtr` and `wrPtr` increments.
  - **Write while full.** When `outFlag`=1 and the FIFO is full, the word is written only if a read happens in the same cycle. Otherwise the word is dropped and `overflow` is set.
  - **End.** When `endFlag`=1, the state moves to DRAIN. A valid `outFlag` word in that same cycle is still captured.
  - `startRise` is ignored in RUN.
- **DRAIN.**
  - `outFlag` and `endFlag` are ignored.
  - The state moves to DONE in the cycle after `count` becomes 0. If `count` is already 0 on entry, DONE follows one cycle later.
- **DONE.**
  - `done`=1.
  - `startRise` starts a new run exactly as it does from IDLE.
- **Read side.**
  - A read transfer occurs when `rdValid & rdReady`, and is allowed in every state.
  - `rdPtr` increments on each transfer.
  - `rdData` = `mem[rdPtr]` (combinational FIFO-head read).
- **Pointers.** Both pointers are `PTRWIDTH` bits and wrap from `DEPTH-1` to 0.
  - `count` updates by +1 on a write, −1 on a read, and stays unchanged on a simultaneous read and write.
  - full = (`count`==`DEPTH`); empty = (`count`==0).
- **Empty FIFO.** A simultaneous write with `rdReady` on an empty FIFO produces no read, because `rdValid`=0. The word is stored.
- **Counter safety.** `count` never exceeds `DEPTH` and never goes below 0.

## Timing

- **Reset values.** While `reset`=0, asynchronously:
  - state IDLE, `start_q`=0;
  - `startIO`=0, `rdValid`=0, `count`=0, `overflow`=0, `done`=0;
  - both pointers 0.
  - FIFO contents are not reset, and `rdData` is don't-care while `rdValid`=0.
- **Start latency.** If `startRise` is sampled at edge N, `startIO`=1 during cycle N→N+1 only, and the state is RUN from edge N.
- **Capture latency.** A word with `outFlag` sampled at edge N gives `rdValid`=1 and `rdData`=that word after edge N, provided the FIFO was empty.
- **Read timing.** A transfer at edge N presents the next word, or drops `rdValid`, after edge N.
- **Status outputs.** `overflow` and `done` are registered and change one cycle after their cause.
- **Reset mid-run.** Assertion in any state discards all FIFO contents and returns to IDLE. No `startIO` is generated until a new `startRise` after reset release.

## Test plan

- **Basic run.** Reset, then `start` 0→1. Expect `startIO` high for exactly 1 cycle. Then send 3 `outFlag` words 0x000000001, 0x000000002, 0x000000003 with `rdReady`=1. Expect them read in order, each one cycle after capture, with `count` peaking at 1.
- **Overflow.** Hold `rdReady`=0 and send 17 words. Expect `count`=16 and `overflow`=1. Then drain with `rdReady`=1: words 1..16 come out, word 17 is absent, and pointers wrap to 0.
- **Full with simultaneous read.** Fill to 16 words, then pulse `outFlag` and `rdReady` together. Expect `count` to stay 16, `overflow`=0, and the new word read last.
- **End and drain.** With 4 words buffered, assert `endFlag` together with a 5th `outFlag` word. Expect the state to go to DRAIN and the 5th word to be kept. Later `outFlag` pulses are ignored. Expect `done`=1 one cycle after `count` reaches 0.
- **Reset mid-operation.** Reset during RUN with 5 words buffered. Expect `count`=0, `rdValid`=0 and `overflow`=0 immediately. Holding `start` high across reset release produces no `startIO`; toggling `start` low then high does.
- **Restart from DONE.** With `done`=1, apply `startRise`. Expect `done`=0, `startIO` pulsed once, and a second run captured correctly.

Source files
------------

// File: rtl/cpu_output_collector.sv
// Capture side of the CPU output port: launches a run with a startIO pulse, buffers
// every outFlag word in a FWFT FIFO and hands it downstream over valid/ready.
module cpu_output_collector #(
  parameter int WIDTH    = 36,
  parameter int DEPTH    = 16,
  parameter int PTRWIDTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic                startIO,
  input  logic                outFlag,
  input  logic                endFlag,
  input  logic [WIDTH-1:0]    dataIn,
  output logic                rdValid,
  input  logic                rdReady,
  output logic [WIDTH-1:0]    rdData,
  output logic [PTRWIDTH:0]   count,
  output logic                overflow,
  output logic                done,
  output logic [1:0]          fsmState
);

  // Handshake: a word moves downstream on every rising clock edge where
  // rdValid and rdReady are both high; rdValid never depends on rdReady.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [PTRWIDTH:0] FULLCOUNT = (PTRWIDTH+1)'(DEPTH);

  state_t              state;
  logic                start_q;
  logic                armed;
  logic [PTRWIDTH-1:0] wrPtr;
  logic [PTRWIDTH-1:0] rdPtr;
  logic [WIDTH-1:0]    mem [DEPTH];

  logic startRise;
  logic full;
  logic rdEn;
  logic wrEn;
  logic dropWord;

  // armed blocks a rise that is really start held high across reset release
  assign startRise = start & ~start_q & armed;
  assign full      = (count == FULLCOUNT);
  assign rdValid   = (count != '0);
  assign rdEn      = rdValid & rdReady;
  assign wrEn      = (state == RUN) & outFlag & (~full | rdEn);
  assign dropWord  = (state == RUN) & outFlag & full & ~rdEn;
  assign rdData    = mem[rdPtr];
  assign fsmState  = state;

  always_ff @(posedge clock) begin
    if (wrEn) mem[wrPtr] <= dataIn;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      armed    <= 1'b0;
      startIO  <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      wrPtr    <= '0;
      rdPtr    <= '0;
    end else begin
      start_q <= start;
      if (!start) armed <= 1'b1;
      startIO <= 1'b0;

      if (wrEn) wrPtr <= wrPtr + PTRWIDTH'(1);
      if (rdEn) rdPtr <= rdPtr + PTRWIDTH'(1);

      case ({wrEn, rdEn})
        2'b10:   count <= count + (PTRWIDTH+1)'(1);
        2'b01:   count <= count - (PTRWIDTH+1)'(1);
        default: count <= count;
      endcase

      case (state)
        IDLE, DONE: begin
          if (startRise) begin
            state    <= RUN;
            startIO  <= 1'b1;
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
          end
        end
        RUN: begin
          if (dropWord) overflow <= 1'b1;
          if (endFlag)  state    <= DRAIN;
        end
        DRAIN: begin
          if (count == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_output_collector.sv
// Bench for cpu_output_collector: scenario tasks drive at the falling edge and
// check outputs there against a scoreboard queue and an occupancy model.
module tb_cpu_output_collector;

  localparam int W = 36;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         startIO;
  logic         outFlag;
  logic         endFlag;
  logic [W-1:0] dataIn;
  logic         rdValid;
  logic         rdReady;
  logic [W-1:0] rdData;
  logic [4:0]   count;
  logic         overflow;
  logic         done;
  logic [1:0]   fsmState;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;

  int           checks = 0;
  int           errors = 0;
  int           mcount = 0;
  int           peak   = 0;
  logic [W-1:0] exp_q[$];

  cpu_output_collector dut (
    .clock(clock), .reset(reset), .start(start), .startIO(startIO),
    .outFlag(outFlag), .endFlag(endFlag), .dataIn(dataIn),
    .rdValid(rdValid), .rdReady(rdReady), .rdData(rdData),
    .count(count), .overflow(overflow), .done(done), .fsmState(fsmState)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  // One cycle: checks occupancy, scores any read, applies inputs, advances.
  task automatic drive(input logic o, input logic e, input logic r,
                       input logic [W-1:0] d, input logic keep);
    logic         rd;
    logic [W-1:0] exp;
    outFlag = o; endFlag = e; rdReady = r; dataIn = d;
    checks++;
    if (count !== 5'(mcount)) begin
      errors++; $display("FAIL count got %0d exp %0d", count, mcount);
    end
    checks++;
    if (rdValid !== (mcount != 0)) begin
      errors++; $display("FAIL rdValid got %b exp %b", rdValid, (mcount != 0));
    end
    if (int'(count) > peak) peak = int'(count);
    rd = (mcount != 0) && r;
    if (rd) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL scoreboard_empty got %0h exp none", rdData);
      end else begin
        exp = exp_q.pop_front();
        if (rdData !== exp) begin
          errors++; $display("FAIL rdData got %0h exp %0h", rdData, exp);
        end
      end
    end
    if (keep) exp_q.push_back(d);
    mcount = mcount + int'(keep) - int'(rd);
    @(negedge clock);
  endtask

  task automatic start_run();
    outFlag = 1'b0; endFlag = 1'b0; rdReady = 1'b0; dataIn = '0;
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    mcount = 0;
    exp_q.delete();
    @(negedge clock);
    checks++;
    if (startIO !== 1'b1) begin errors++; $display("FAIL startIO_pulse got %b exp 1", startIO); end
    checks++;
    if (fsmState !== S_RUN) begin errors++; $display("FAIL state_run got %0d exp %0d", fsmState, S_RUN); end
    checks++;
    if (done !== 1'b0 || overflow !== 1'b0 || count !== 5'd0) begin
      errors++; $display("FAIL start_clear got done=%b ovf=%b cnt=%0d exp 0 0 0", done, overflow, count);
    end
    start = 1'b0;
    @(negedge clock);
    checks++;
    if (startIO !== 1'b0) begin errors++; $display("FAIL startIO_width got %b exp 0", startIO); end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; outFlag = 1'b0; endFlag = 1'b0; rdReady = 1'b0; dataIn = '0;
    mcount = 0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    checks++;
    if ({startIO, rdValid, overflow, done} !== 4'b0 || count !== 5'd0 || fsmState !== S_IDLE) begin
      errors++;
      $display("FAIL reset_values got sio=%b v=%b ovf=%b done=%b cnt=%0d st=%0d exp all 0",
               startIO, rdValid, overflow, done, count, fsmState);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    test_reset();
    start_run();
    peak = 0;
    for (int i = 1; i <= 3; i++) drive(1'b1, 1'b0, 1'b1, W'(i), 1'b1);
    repeat (2) drive(1'b0, 1'b0, 1'b1, '0, 1'b0);
    checks++;
    if (peak !== 1) begin errors++; $display("FAIL basic_peak got %0d exp 1", peak); end
  endtask

  task automatic test_overflow();
    test_reset();
    start_run();
    for (int i = 1; i <= 17; i++) drive(1'b1, 1'b0, 1'b0, W'(i), (i <= 16));
    checks++;
    if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", count); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    repeat (17) drive(1'b0, 1'b0, 1'b1, '0, 1'b0);
    checks++;
    if (dut.wrPtr !== 4'd0 || dut.rdPtr !== 4'd0) begin
      errors++; $display("FAIL ptr_wrap got wr=%0d rd=%0d exp 0 0", dut.wrPtr, dut.rdPtr);
    end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_full_simul();
    test_reset();
    start_run();
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b0, rand_word(), 1'b1);
    drive(1'b1, 1'b0, 1'b1, 36'h0ABCDEF01, 1'b1);
    checks++;
    if (count !== 5'd16 || overflow !== 1'b0) begin
      errors++; $display("FAIL full_simul got cnt=%0d ovf=%b exp 16 0", count, overflow);
    end
    repeat (16) drive(1'b0, 1'b0, 1'b1, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_end_drain();
    test_reset();
    start_run();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, rand_word(), 1'b1);
    drive(1'b1, 1'b1, 1'b0, 36'h555555555, 1'b1);
    checks++;
    if (fsmState !== S_DRAIN) begin errors++; $display("FAIL drain_state got %0d exp %0d", fsmState, S_DRAIN); end
    drive(1'b1, 1'b0, 1'b0, 36'hBADBADBAD, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 36'hBADBADBAD, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 1'b1, '0, 1'b0);
    checks++;
    if (done !== 1'b0 || fsmState !== S_DRAIN) begin
      errors++; $display("FAIL done_early got done=%b st=%0d exp 0 %0d", done, fsmState, S_DRAIN);
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (done !== 1'b1 || fsmState !== S_DONE) begin
      errors++; $display("FAIL done_set got done=%b st=%0d exp 1 %0d", done, fsmState, S_DONE);
    end
  endtask

  task automatic test_restart();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL restart_pre got done=%b exp 1", done); end
    start_run();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, rand_word(), 1'b1);
    drive(1'b0, 1'b1, 1'b1, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (done !== 1'b1 || fsmState !== S_DONE) begin
      errors++; $display("FAIL restart_done got done=%b st=%0d exp 1 %0d", done, fsmState, S_DONE);
    end
  endtask

  task automatic test_reset_mid();
    test_reset();
    start_run();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, rand_word(), 1'b1);
    reset = 1'b0;
    start = 1'b1;
    outFlag = 1'b0; rdReady = 1'b0;
    #1;
    checks++;
    if (count !== 5'd0 || rdValid !== 1'b0 || overflow !== 1'b0 || fsmState !== S_IDLE) begin
      errors++; $display("FAIL mid_reset got cnt=%0d v=%b ovf=%b st=%0d exp 0 0 0 0", count, rdValid, overflow, fsmState);
    end
    mcount = 0;
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (startIO !== 1'b0 || fsmState !== S_IDLE) begin
        errors++; $display("FAIL held_start got sio=%b st=%0d exp 0 %0d", startIO, fsmState, S_IDLE);
      end
    end
    start_run();
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b1, rand_word(), 1'b1);
    drive(1'b0, 1'b0, 1'b1, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_simul();
    test_end_drain();
    test_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
